fetch_decode_unit: RTL and testbench

- Front end of the single-cycle MIPS-subset CPU: program counter, instruction memory and main control decoder in one block.
- Each clk edge advances the PC and presents the fetched instruction with its decoded fields and datapath control signals.
- Consumers are the register file (register_mem), the ALU and the data memory.

---
 rtl/fetch_decode_pkg.sv | 53 +++++
 rtl/fetch_decode_unit_ctrl_decoder.sv | 79 +++++++
 rtl/fetch_decode_unit.sv | 100 ++++++++++
 tb/tb_fetch_decode_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared constants and types for the MIPS-subset front end.
// Opcode/funct values, ALU control codes and the decoded control bundle.
package fetch_decode_pkg;

  localparam int ADDR_W_DEF = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_LUI = 4'b1010
  } alu_ctrl_t;

  typedef struct packed {
    logic      reg_dst;
    logic      alu_src;
    logic      mem_reg;
    logic      reg_write;
    logic      mem_write;
    logic      mem_read;
    logic      ext_zero;
    alu_ctrl_t alu_ctrl;
    logic      illegal;
    logic      beq;
    logic      bne;
    logic      jump;
  } ctrl_t;

endpackage

// File: rtl/fetch_decode_unit_ctrl_decoder.sv
// Main control decoder: op/funct to datapath controls.
// Purely combinational; undecodable encodings flag illegal with all enables low.
module ctrl_decoder
  import fetch_decode_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    ctrl.alu_ctrl = ALU_ADD;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_write = 1'b1;
        unique case (1'b1)
          (funct == F_ADD): ctrl.alu_ctrl = ALU_ADD;
          (funct == F_SUB): ctrl.alu_ctrl = ALU_SUB;
          (funct == F_AND): ctrl.alu_ctrl = ALU_AND;
          (funct == F_OR):  ctrl.alu_ctrl = ALU_OR;
          (funct == F_SLT): ctrl.alu_ctrl = ALU_SLT;
          (funct == F_SLL): ctrl.alu_ctrl = ALU_SLL;
          (funct == F_SRL): ctrl.alu_ctrl = ALU_SRL;
          default: begin
            ctrl.reg_dst = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      (op == OP_ADDI): begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      (op == OP_ANDI): begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.ext_zero = 1'b1;
        ctrl.alu_ctrl = ALU_AND;
      end
      (op == OP_ORI): begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.ext_zero = 1'b1;
        ctrl.alu_ctrl = ALU_OR;
      end
      (op == OP_LUI): begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.ext_zero = 1'b1;
        ctrl.alu_ctrl = ALU_LUI;
      end
      (op == OP_LW): begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_reg = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      (op == OP_SW): begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      (op == OP_BEQ): begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.beq = 1'b1;
      end
      (op == OP_BNE): begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.bne = 1'b1;
      end
      // jal shares the jump path; no link register in this subset
      (op == OP_J), (op == OP_JAL): ctrl.jump = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Single-cycle front end: PC, instruction memory and control decode.
// Memory read is combinational; clr resets the PC but never the memory.
module fetch_decode_unit
  import fetch_decode_pkg::*;
#(
  parameter int              ADDR_W     = ADDR_W_DEF,
  parameter int              MEM_DEPTH  = 64,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter string           INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pc_en,
  input  logic              alu_zero,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instruction,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_reg,
  output logic              reg_write,
  output logic              mem_write,
  output logic              mem_read,
  output logic              ext_zero,
  output logic [3:0]        alu_ctrl,
  output logic              illegal
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [31:0]       mem [MEM_DEPTH];
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] next_pc;
  ctrl_t             ctrl;
  logic              unused_bits;

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr[IDX_W+1:2]] <= imem_wdata;
  end

  assign instruction = mem[pc[IDX_W+1:2]];
  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign rd    = instruction[15:11];
  assign shamt = instruction[10:6];
  assign funct = instruction[5:0];
  assign imm   = instruction[15:0];

  ctrl_decoder u_dec (
    .op    (op),
    .funct (funct),
    .ctrl  (ctrl)
  );

  assign reg_dst   = ctrl.reg_dst;
  assign alu_src   = ctrl.alu_src;
  assign mem_reg   = ctrl.mem_reg;
  assign reg_write = ctrl.reg_write & ~clr;
  assign mem_write = ctrl.mem_write & ~clr;
  assign mem_read  = ctrl.mem_read;
  assign ext_zero  = ctrl.ext_zero;
  assign alu_ctrl  = ctrl.alu_ctrl;
  assign illegal   = ctrl.illegal;

  assign pc4    = pc + ADDR_W'(4);
  assign br_tgt = pc4 + ADDR_W'({{16{imm[15]}}, imm, 2'b00});
  assign j_tgt  = ADDR_W'({instruction[25:0], 2'b00});

  always_comb begin
    next_pc = pc4;
    if ((ctrl.beq & alu_zero) | (ctrl.bne & ~alu_zero))
      next_pc = br_tgt;
    else if (ctrl.jump)
      next_pc = j_tgt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) pc <= RESET_ADDR;
    else if (pc_en) pc <= next_pc;
  end

  assign unused_bits = ^{imem_waddr[1:0], pc[1:0]};

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        pc_en;
  logic        alu_zero;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [7:0]  pc;
  logic [31:0] instruction;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        reg_dst, alu_src, mem_reg, reg_write;
  logic        mem_write, mem_read, ext_zero, illegal;
  logic [3:0]  alu_ctrl;

  int n_checks = 0;
  int n_fail = 0;

  fetch_decode_unit dut (
    .clk         (clk),
    .clr         (clr),
    .pc_en       (pc_en),
    .alu_zero    (alu_zero),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .pc          (pc),
    .instruction (instruction),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm         (imm),
    .reg_dst     (reg_dst),
    .alu_src     (alu_src),
    .mem_reg     (mem_reg),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .ext_zero    (ext_zero),
    .alu_ctrl    (alu_ctrl),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    imem_we = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    step();
    imem_we = 1'b0;
  endtask

  // pulse clr between edges, then walk sequentially to address a
  task automatic go_to(input logic [7:0] a);
    pc_en = 1'b0;
    clr = 1'b1;
    #1;
    clr = 1'b0;
    pc_en = 1'b1;
    repeat (int'(a) / 4) step();
    pc_en = 1'b0;
  endtask

  task automatic test_reset();
    write_word(8'h00, 32'h20010005);
    go_to(8'h10);
    n_checks++;
    if (pc !== 8'h10) begin
      n_fail++;
      $display("FAIL reset_pre_pc got %h want 10", pc);
    end
    clr = 1'b1;
    #1;
    n_checks++;
    if (pc !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async_pc got %h want 00", pc);
    end
    n_checks++;
    if (alu_src !== 1'b1 || alu_ctrl !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_decode got alu_src=%b alu_ctrl=%b want 1 0010",
               alu_src, alu_ctrl);
    end
    n_checks++;
    if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wr_gate got rw=%b mw=%b want 0 0",
               reg_write, mem_write);
    end
    pc_en = 1'b1;
    step();
    n_checks++;
    if (pc !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold got %h want 00", pc);
    end
    pc_en = 1'b0;
    clr = 1'b0;
    #1;
    n_checks++;
    if (reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rw got %b want 1", reg_write);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] prog [4];
    prog[0] = 32'h20010005;
    prog[1] = 32'h8C220004;
    prog[2] = 32'hAC220004;
    prog[3] = 32'h00430822;
    for (int i = 0; i < 4; i++) write_word(8'(i * 4), prog[i]);
    go_to(8'h00);
    pc_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pc !== 8'(i * 4) || instruction !== prog[i]) begin
        n_fail++;
        $display("FAIL seq_fetch%0d got pc=%h ins=%h want pc=%h ins=%h",
                 i, pc, instruction, 8'(i * 4), prog[i]);
      end
      step();
    end
    pc_en = 1'b0;
    go_to(8'hFC);
    n_checks++;
    if (pc !== 8'hFC) begin
      n_fail++;
      $display("FAIL wrap_pre got %h want fc", pc);
    end
    pc_en = 1'b1;
    step();
    pc_en = 1'b0;
    n_checks++;
    if (pc !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap got %h want 00", pc);
    end
  endtask

  task automatic test_decode();
    go_to(8'h04);
    n_checks++;
    if (mem_reg !== 1'b1 || mem_read !== 1'b1 || reg_write !== 1'b1 ||
        reg_dst !== 1'b0 || rs !== 5'd1 || rt !== 5'd2 ||
        imm !== 16'h0004 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_lw got mr=%b rd=%b rw=%b dst=%b rs=%0d rt=%0d imm=%h il=%b",
               mem_reg, mem_read, reg_write, reg_dst, rs, rt, imm, illegal);
    end
    go_to(8'h08);
    n_checks++;
    if (mem_write !== 1'b1 || reg_write !== 1'b0 || alu_ctrl !== 4'b0010) begin
      n_fail++;
      $display("FAIL dec_sw got mw=%b rw=%b alu=%b want 1 0 0010",
               mem_write, reg_write, alu_ctrl);
    end
    go_to(8'h0C);
    n_checks++;
    if (reg_dst !== 1'b1 || alu_ctrl !== 4'b0110 || rd !== 5'd1 ||
        reg_write !== 1'b1 || alu_src !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_sub got dst=%b alu=%b rd=%0d rw=%b src=%b",
               reg_dst, alu_ctrl, rd, reg_write, alu_src);
    end
    go_to(8'h10);
    n_checks++;
    if (instruction !== 32'h0 || alu_ctrl !== 4'b1000 ||
        reg_write !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_nop got ins=%h alu=%b rw=%b il=%b",
               instruction, alu_ctrl, reg_write, illegal);
    end
    write_word(8'h10, 32'h34210001);
    n_checks++;
    if (instruction !== 32'h34210001 || ext_zero !== 1'b1 ||
        alu_ctrl !== 4'b0001 || alu_src !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_ori got ins=%h ez=%b alu=%b src=%b",
               instruction, ext_zero, alu_ctrl, alu_src);
    end
    write_word(8'h10, 32'h3C011234);
    n_checks++;
    if (alu_ctrl !== 4'b1010 || ext_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_lui got alu=%b ez=%b want 1010 1", alu_ctrl, ext_zero);
    end
    write_word(8'h10, 32'h0022182A);
    n_checks++;
    if (alu_ctrl !== 4'b0111 || reg_dst !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_slt got alu=%b dst=%b want 0111 1", alu_ctrl, reg_dst);
    end
    write_word(8'h10, 32'h00000000);
  endtask

  task automatic test_branch();
    logic [31:0] ins [3];
    logic        z [3];
    logic [7:0]  exp [3];
    ins[0] = 32'h1000FFFE; z[0] = 1'b1; exp[0] = 8'h04;
    ins[1] = 32'h1000FFFE; z[1] = 1'b0; exp[1] = 8'h0C;
    ins[2] = 32'h14000003; z[2] = 1'b0; exp[2] = 8'h18;
    for (int i = 0; i < 3; i++) begin
      write_word(8'h08, ins[i]);
      alu_zero = 1'b1;
      go_to(8'h08);
      n_checks++;
      if (alu_ctrl !== 4'b0110 || reg_write !== 1'b0 || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL br_decode%0d got alu=%b rw=%b il=%b", i, alu_ctrl,
                 reg_write, illegal);
      end
      alu_zero = z[i];
      pc_en = 1'b1;
      step();
      pc_en = 1'b0;
      n_checks++;
      if (pc !== exp[i]) begin
        n_fail++;
        $display("FAIL branch%0d got pc=%h want %h", i, pc, exp[i]);
      end
    end
    alu_zero = 1'b0;
    write_word(8'h08, 32'hAC220004);
  endtask

  task automatic test_jump_illegal();
    write_word(8'h20, 32'h08000010);
    write_word(8'h40, 32'hFC000000);
    write_word(8'h44, 32'h0000003F);
    go_to(8'h20);
    step();
    n_checks++;
    if (pc !== 8'h20) begin
      n_fail++;
      $display("FAIL jump_stall got pc=%h want 20", pc);
    end
    pc_en = 1'b1;
    step();
    pc_en = 1'b0;
    n_checks++;
    if (pc !== 8'h40) begin
      n_fail++;
      $display("FAIL jump got pc=%h want 40", pc);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (illegal !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0 ||
          mem_read !== 1'b0 || alu_ctrl !== 4'b0010) begin
        n_fail++;
        $display("FAIL illegal%0d got il=%b rw=%b mw=%b mr=%b alu=%b",
                 i, illegal, reg_write, mem_write, mem_read, alu_ctrl);
      end
      alu_zero = 1'b1;
      pc_en = 1'b1;
      step();
      pc_en = 1'b0;
      alu_zero = 1'b0;
      n_checks++;
      if (pc !== 8'(8'h44 + i * 4)) begin
        n_fail++;
        $display("FAIL illegal_pc%0d got %h want %h", i, pc, 8'(8'h44 + i * 4));
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    pc_en = 1'b0;
    alu_zero = 1'b0;
    imem_we = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    #2;
    n_checks++;
    if (pc !== 8'h00 || reg_write !== 1'b0 || instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL init got pc=%h rw=%b ins=%h want 00 0 0", pc, reg_write,
               instruction);
    end
    clr = 1'b0;
    test_reset();
    test_sequential();
    test_decode();
    test_branch();
    test_jump_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
